// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
//   Takes coprocessor instructions from the integer pipeline's decode stage,
//   one per valid/ready handshake. It then drives the floating-point
//   coprocessor and data-memory strobes for three kinds of instruction:
//   arithmetic ops, lws (memory -> coprocessor register) and sws
//   (coprocessor register -> memory).
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   instr_valid     instr carries a coprocessor instruction
//   instr[31:0]     [31:26] op, [25:21] fd/ft, [20:16] fs1, [15:11] fs2,
//                   [15:0] imm
//   gpr_base[31:0]  base register value for lws/sws, sampled at accept
//   instr_ready     high only while idle; busy is its complement
//   illegal         one-cycle pulse for an unknown op or a misaligned address
//   mem_addr/mem_read/mem_write/mem_wdata/mem_rdata
//                   data-memory port; read data arrives the cycle after
//                   mem_read
//   cop_opcode/cop_addr_in1/cop_addr_in2/cop_addr_dest/cop_we/cop_wdata/
//   cop_rdata       coprocessor register file / datapath port
//
// Outputs are decoded from registered state. The only exceptions are the two
// data pass-throughs (mem_rdata -> cop_wdata and cop_rdata -> mem_wdata).
// Those are steered combinationally during the single write cycle of lws and
// sws respectively.
// ---------------------------------------------------------------------------
module fpu_issue_ctrl #(
    parameter int OP_LATENCY = 1,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] gpr_base,
    output logic        instr_ready,
    output logic        busy,
    output logic        illegal,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [5:0]  cop_opcode,
    output logic [4:0]  cop_addr_in1,
    output logic [4:0]  cop_addr_in2,
    output logic [4:0]  cop_addr_dest,
    output logic        cop_we,
    output logic [31:0] cop_wdata,
    input  logic [31:0] cop_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXEC   = 3'd1,
        S_LW_REQ = 3'd2,
        S_LW_WR  = 3'd3,
        S_SW_REQ = 3'd4,
        S_SW_WR  = 3'd5,
        S_ILL    = 3'd6
    } state_t;

    localparam logic [5:0] OP_NOP      = 6'b000000;
    localparam logic [5:0] OP_ARITH_LO = 6'b110000;
    localparam logic [5:0] OP_ARITH_HI = 6'b110110;
    localparam logic [5:0] OP_LWS      = 6'b110111;
    localparam logic [5:0] OP_SWS      = 6'b111000;

    // The EXEC cycle that presents the opcode counts toward the latency,
    // so the counter starts one below OP_LATENCY and leaves EXEC at zero.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OP_LATENCY - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [5:0]        op_reg, op_next;
    logic [4:0]        rd_reg, rd_next;
    logic [4:0]        rs1_reg, rs1_next;
    logic [4:0]        rs2_reg, rs2_next;
    logic [31:0]       ea_reg, ea_next;

    // Sign-extended immediate and effective address (wraps mod 2^32).
    logic [31:0] imm_sext;
    logic [31:0] ea_calc;

    assign imm_sext[15:0] = instr[15:0];
    generate
        for (genvar gi = 16; gi < 32; gi++) begin : g_sext
            assign imm_sext[gi] = instr[15];
        end
    endgenerate

    assign ea_calc = gpr_base + imm_sext;

    logic [5:0] in_op;
    logic       in_arith, in_lws, in_sws;

    assign in_op    = instr[31:26];
    assign in_arith = (in_op >= OP_ARITH_LO) && (in_op <= OP_ARITH_HI);
    assign in_lws   = (in_op == OP_LWS);
    assign in_sws   = (in_op == OP_SWS);

    // State register process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            rd_reg    <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            ea_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            rd_reg    <= rd_next;
            rs1_reg   <= rs1_next;
            rs2_reg   <= rs2_next;
            ea_reg    <= ea_next;
        end
    end

    // Next-state process.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        rd_next    = rd_reg;
        rs1_next   = rs1_reg;
        rs2_next   = rs2_reg;
        ea_next    = ea_reg;
        case (state_reg)
            S_IDLE: begin
                if (instr_valid) begin
                    op_next  = in_op;
                    rd_next  = instr[25:21];
                    rs1_next = instr[20:16];
                    rs2_next = instr[15:11];
                    ea_next  = ea_calc;
                    if (in_arith) begin
                        state_next = S_EXEC;
                        cnt_next   = CNT_INIT;
                    end else if (in_lws) begin
                        state_next = (ea_calc[1:0] != 2'b00) ? S_ILL : S_LW_REQ;
                    end else if (in_sws) begin
                        state_next = (ea_calc[1:0] != 2'b00) ? S_ILL : S_SW_REQ;
                    end else begin
                        state_next = S_ILL;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_LW_REQ: state_next = S_LW_WR;
            S_LW_WR:  state_next = S_IDLE;
            S_SW_REQ: state_next = S_SW_WR;
            S_SW_WR:  state_next = S_IDLE;
            S_ILL:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output process: every strobe is owned by exactly one state, which
    // keeps cop_we/opcode and mem_read/mem_write mutually exclusive.
    always_comb begin
        instr_ready   = 1'b0;
        illegal       = 1'b0;
        mem_addr      = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_wdata     = '0;
        cop_opcode    = OP_NOP;
        cop_addr_in1  = '0;
        cop_addr_in2  = '0;
        cop_addr_dest = '0;
        cop_we        = 1'b0;
        cop_wdata     = '0;
        case (state_reg)
            S_IDLE: instr_ready = 1'b1;
            S_EXEC: begin
                cop_opcode    = op_reg;
                cop_addr_in1  = rs1_reg;
                cop_addr_in2  = rs2_reg;
                cop_addr_dest = rd_reg;
            end
            S_LW_REQ: begin
                mem_read = 1'b1;
                mem_addr = ea_reg;
            end
            S_LW_WR: begin
                cop_we       = 1'b1;
                cop_wdata    = mem_rdata;
                cop_addr_in1 = rd_reg;
            end
            S_SW_REQ: begin
                cop_opcode   = OP_SWS;
                cop_addr_in1 = rd_reg;
            end
            S_SW_WR: begin
                mem_write = 1'b1;
                mem_addr  = ea_reg;
                mem_wdata = cop_rdata;
            end
            S_ILL: illegal = 1'b1;
            default: ;
        endcase
    end

    assign busy = ~instr_ready;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] gpr_base = '0;
    logic        instr_ready, busy, illegal;
    logic [31:0] mem_addr;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_wdata;
    logic [5:0]  cop_opcode;
    logic [4:0]  cop_addr_in1, cop_addr_in2, cop_addr_dest;
    logic        cop_we;
    logic [31:0] cop_wdata;
    logic [31:0] cop_rdata = '0;

    int checks   = 0;
    int failures = 0;

    fpu_issue_ctrl #(.OP_LATENCY(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .gpr_base(gpr_base),
        .instr_ready(instr_ready), .busy(busy), .illegal(illegal),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
        .mem_write(mem_write), .mem_wdata(mem_wdata),
        .cop_opcode(cop_opcode), .cop_addr_in1(cop_addr_in1),
        .cop_addr_in2(cop_addr_in2), .cop_addr_dest(cop_addr_dest),
        .cop_we(cop_we), .cop_wdata(cop_wdata), .cop_rdata(cop_rdata)
    );

    always #5 clk = ~clk;

    // Data memory contents as seen by the controller.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h0000_00FC) ? 32'h3FC0_0000 : {a[15:0], ~a[15:0]};
    endfunction

    // Synchronous-read memory: data for a read strobe shows up next cycle.
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem_model(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe exclusivity, checked in every observed cycle.
    task automatic check_excl();
        check("excl_we_op", 32'(cop_we && (cop_opcode != 6'd0)), 32'd0);
        check("excl_rd_wr", 32'(mem_read && mem_write), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(instr_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_strobes"}, {28'd0, illegal, mem_read, mem_write, cop_we}, 32'd0);
        check({tag, "_opcode"}, 32'(cop_opcode), 32'd0);
    endtask

    function automatic logic [31:0] mk_arith(input logic [5:0] op, input logic [4:0] fd,
                                             input logic [4:0] fs1, input logic [4:0] fs2);
        return {op, fd, fs1, fs2, 11'd0};
    endfunction

    function automatic logic [31:0] mk_mem(input logic [5:0] op, input logic [4:0] ft,
                                           input logic [15:0] imm);
        return {op, ft, 5'd0, imm};
    endfunction

    // Issues one instruction from IDLE and checks every cycle until the
    // controller is ready again, against the expected per-kind trace.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] base);
        logic [5:0]  op;
        logic [31:0] ea;
        op = ins[31:26];
        ea = base + {{16{ins[15]}}, ins[15:0]};
        check("pre_ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = ins;
        gpr_base    = base;
        step();
        instr_valid = 1'b0;
        if (op >= 6'b110000 && op <= 6'b110110) begin
            for (int i = 0; i < LAT; i++) begin
                check("ar_opcode", 32'(cop_opcode), 32'(op));
                check("ar_regs", {17'd0, cop_addr_in1, cop_addr_in2, cop_addr_dest},
                      {17'd0, ins[20:16], ins[15:11], ins[25:21]});
                check("ar_strobes", {29'd0, mem_read, mem_write, cop_we}, 32'd0);
                check_excl();
                step();
            end
        end else if ((op == 6'b110111 || op == 6'b111000) && ea[1:0] == 2'b00) begin
            if (op == 6'b110111) begin
                check("lw_req_rd", 32'(mem_read), 32'd1);
                check("lw_req_addr", mem_addr, ea);
                check("lw_req_op", 32'(cop_opcode), 32'd0);
                check_excl();
                step();
                check("lw_wr_we", 32'(cop_we), 32'd1);
                check("lw_wr_in1", 32'(cop_addr_in1), 32'(ins[25:21]));
                check("lw_wr_data", cop_wdata, mem_model(ea));
                check("lw_wr_rd", 32'(mem_read), 32'd0);
                check_excl();
                step();
            end else begin
                check("sw_req_op", 32'(cop_opcode), 32'h38);
                check("sw_req_in1", 32'(cop_addr_in1), 32'(ins[25:21]));
                check("sw_req_wr", 32'(mem_write), 32'd0);
                check_excl();
                step();
                check("sw_wr_wr", 32'(mem_write), 32'd1);
                check("sw_wr_addr", mem_addr, ea);
                check("sw_wr_data", mem_wdata, cop_rdata);
                check("sw_wr_op", 32'(cop_opcode), 32'd0);
                check_excl();
                step();
            end
        end else begin
            check("ill_pulse", 32'(illegal), 32'd1);
            check("ill_strobes", {28'd0, mem_read, mem_write, cop_we, 1'b0}, 32'd0);
            check("ill_op", 32'(cop_opcode), 32'd0);
            step();
        end
        check_idle("post");
    endtask

    initial begin
        // Reset state.
        step();
        check_idle("rst");
        check("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;
        step();
        check_idle("rst_rel");

        // Reset in the middle of SW_REQ drops the store.
        cop_rdata   = 32'h1234_5678;
        instr_valid = 1'b1;
        instr       = mk_mem(6'b111000, 5'd9, 16'h0010);
        gpr_base    = 32'h0000_0100;
        step();
        instr_valid = 1'b0;
        check("mid_sw_op", 32'(cop_opcode), 32'h38);
        rst = 1'b1;
        #1;
        check_idle("mid_rst");
        step();
        rst = 1'b0;
        step();
        check_idle("after_rst");
        check("after_rst_wr", 32'(mem_write), 32'd0);

        // Arithmetic add with a back-to-back second instruction held waiting.
        instr_valid = 1'b1;
        instr       = mk_arith(6'b110000, 5'd3, 5'd1, 5'd2);
        step();
        instr       = mk_arith(6'b110001, 5'd4, 5'd5, 5'd6);
        for (int i = 0; i < LAT; i++) begin
            check("add_opcode", 32'(cop_opcode), 32'h30);
            check("add_regs", {17'd0, cop_addr_in1, cop_addr_in2, cop_addr_dest},
                  {17'd0, 5'd1, 5'd2, 5'd3});
            check("add_ready", 32'(instr_ready), 32'd0);
            step();
        end
        check_idle("add_done");
        step();
        instr_valid = 1'b0;
        check("b2b_opcode", 32'(cop_opcode), 32'h31);
        check("b2b_dest", 32'(cop_addr_dest), 32'd4);
        step();
        step();
        check("b2b_last", 32'(cop_opcode), 32'h31);
        step();
        check_idle("b2b_done");

        // lws ft=5, ea = 0x100 + sext(0xFFFC) = 0xFC.
        run_instr(mk_mem(6'b110111, 5'd5, 16'hFFFC), 32'h0000_0100);

        // sws ft=7, ea = 0xFFFFFFFC + 8 wraps to 0x4.
        cop_rdata = 32'hC040_0000;
        run_instr(mk_mem(6'b111000, 5'd7, 16'h0008), 32'hFFFF_FFFC);

        // Unknown opcode, then a misaligned lws.
        run_instr(mk_arith(6'b101010, 5'd1, 5'd2, 5'd3), 32'd0);
        run_instr(mk_mem(6'b110111, 5'd5, 16'h0002), 32'h0000_0100);

        // Random op stream.
        for (int n = 0; n < 24; n++) begin
            int unsigned kind;
            logic [5:0]  op;
            logic [15:0] imm;
            logic [31:0] base;
            kind      = $urandom_range(0, 4);
            cop_rdata = $urandom;
            base      = $urandom & 32'hFFFF_FFFC;
            imm       = 16'($urandom_range(0, 16383)) << 2;
            case (kind)
                0: begin
                    op = 6'b110000 + 6'($urandom_range(0, 6));
                    run_instr(mk_arith(op, 5'($urandom), 5'($urandom), 5'($urandom)), base);
                end
                1: run_instr(mk_mem(6'b110111, 5'($urandom), imm), base);
                2: run_instr(mk_mem(6'b111000, 5'($urandom), imm), base);
                3: run_instr(mk_mem(6'($urandom_range(0, 47)), 5'($urandom), imm), base);
                default: begin
                    imm = imm | 16'($urandom_range(1, 3));
                    op  = ($urandom_range(0, 1) == 0) ? 6'b110111 : 6'b111000;
                    run_instr(mk_mem(op, 5'($urandom), imm), base);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
